// File: rtl/acorn128_seq_ctrl.sv
// acorn128_seq_ctrl
// Phase sequencer for the ACORN-128 bit-serial datapath. One state step is
// issued per cycle through INIT, AD, ENC and FIN. The sequencer supplies the
// per-step message bit and the ca/cb control bits, and it captures keystream
// into the ciphertext and tag registers.
module acorn128_seq_ctrl #(
    parameter int AD_LEN  = 128,
    parameter int MSG_LEN = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key_in,
    input  logic [127:0]       iv_in,
    input  logic [AD_LEN-1:0]  ad_in,
    input  logic [MSG_LEN-1:0] plaintext_in,
    input  logic               ks_in,
    output logic               state_clr,
    output logic               step_en,
    output logic               mbit_out,
    output logic               ca_out,
    output logic               cb_out,
    output logic [2:0]         phase_out,
    output logic               busy,
    output logic               done,
    output logic [MSG_LEN-1:0] cipher_out,
    output logic [127:0]       tag_out
);

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_INIT = 3'd1,
        PH_AD   = 3'd2,
        PH_ENC  = 3'd3,
        PH_FIN  = 3'd4,
        PH_DONE = 3'd5
    } phase_t;

    // Step indices that bound each phase and its padding, all sized to the
    // 11-bit step counter.
    localparam logic [10:0] INIT_LAST    = 11'd1791;
    localparam logic [10:0] AD_DATA_END  = 11'(AD_LEN);
    localparam logic [10:0] AD_PAD_END   = 11'(AD_LEN + 128);
    localparam logic [10:0] AD_LAST      = 11'(AD_LEN + 255);
    localparam logic [10:0] MSG_DATA_END = 11'(MSG_LEN);
    localparam logic [10:0] MSG_PAD_END  = 11'(MSG_LEN + 128);
    localparam logic [10:0] MSG_LAST     = 11'(MSG_LEN + 255);
    localparam logic [10:0] FIN_LAST     = 11'd767;
    localparam logic [10:0] TAG_FIRST    = 11'd640;

    // Bit-index widths for the AD and plaintext vectors. A 1-bit vector still
    // gets a 1-bit index.
    localparam int AW = (AD_LEN  > 1) ? $clog2(AD_LEN)  : 1;
    localparam int MW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    phase_t             r_phase;
    logic [10:0]        r_cnt;
    logic [127:0]       r_key;
    logic [127:0]       r_iv;
    logic [AD_LEN-1:0]  r_ad;
    logic [MSG_LEN-1:0] r_pt;
    logic [MSG_LEN-1:0] r_cipher;
    logic [127:0]       r_tag;

    logic [AW-1:0]      w_adIdx;
    logic [MW-1:0]      w_msgIdx;
    logic               w_mbit;
    logic               w_ca;
    logic               w_cb;

    assign w_adIdx  = r_cnt[AW-1:0];
    assign w_msgIdx = r_cnt[MW-1:0];

    // Derive the message and control bits for the current step. The value
    // depends only on the phase and the step count. The INIT key bits repeat
    // with period 128, so the low 7 counter bits select both the key bit and
    // the IV bit.
    always_comb begin
        w_mbit = 1'b0;
        w_ca   = 1'b0;
        w_cb   = 1'b0;
        case (r_phase)
            PH_INIT: begin
                w_ca = 1'b1;
                w_cb = 1'b1;
                if (r_cnt < 11'd128) begin
                    w_mbit = r_key[r_cnt[6:0]];
                end else if (r_cnt < 11'd256) begin
                    w_mbit = r_iv[r_cnt[6:0]];
                end else if (r_cnt == 11'd256) begin
                    w_mbit = ~r_key[0];
                end else begin
                    w_mbit = r_key[r_cnt[6:0]];
                end
            end
            PH_AD: begin
                w_cb = 1'b1;
                if (r_cnt < AD_DATA_END) begin
                    w_mbit = r_ad[w_adIdx];
                    w_ca   = 1'b1;
                end else if (r_cnt == AD_DATA_END) begin
                    w_mbit = 1'b1;
                    w_ca   = 1'b1;
                end else if (r_cnt < AD_PAD_END) begin
                    w_ca = 1'b1;
                end
            end
            PH_ENC: begin
                if (r_cnt < MSG_DATA_END) begin
                    w_mbit = r_pt[w_msgIdx];
                    w_ca   = 1'b1;
                end else if (r_cnt == MSG_DATA_END) begin
                    w_mbit = 1'b1;
                    w_ca   = 1'b1;
                end else if (r_cnt < MSG_PAD_END) begin
                    w_ca = 1'b1;
                end
            end
            PH_FIN: begin
                w_ca = 1'b1;
                w_cb = 1'b1;
            end
            default: begin
                w_mbit = 1'b0;
            end
        endcase
    end

    // Phase sequencer: latch the job, step through the phases without idle
    // cycles between them, and capture keystream into cipher and tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_IDLE;
            r_cnt    <= 11'd0;
            r_key    <= '0;
            r_iv     <= '0;
            r_ad     <= '0;
            r_pt     <= '0;
            r_cipher <= '0;
            r_tag    <= '0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        r_key    <= key_in;
                        r_iv     <= iv_in;
                        r_ad     <= ad_in;
                        r_pt     <= plaintext_in;
                        r_cipher <= '0;
                        r_tag    <= '0;
                        r_cnt    <= 11'd0;
                        r_phase  <= PH_INIT;
                    end
                end
                PH_INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        r_cnt   <= 11'd0;
                        r_phase <= PH_AD;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                PH_AD: begin
                    if (r_cnt == AD_LAST) begin
                        r_cnt   <= 11'd0;
                        r_phase <= PH_ENC;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                PH_ENC: begin
                    if (r_cnt < MSG_DATA_END) begin
                        r_cipher[w_msgIdx] <= r_pt[w_msgIdx] ^ ks_in;
                    end
                    if (r_cnt == MSG_LAST) begin
                        r_cnt   <= 11'd0;
                        r_phase <= PH_FIN;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                PH_FIN: begin
                    if (r_cnt >= TAG_FIRST) begin
                        r_tag[r_cnt[6:0]] <= ks_in;
                    end
                    if (r_cnt == FIN_LAST) begin
                        r_cnt   <= 11'd0;
                        r_phase <= PH_DONE;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                PH_DONE: begin
                    r_cnt   <= 11'd0;
                    r_phase <= PH_IDLE;
                end
                default: begin
                    r_cnt   <= 11'd0;
                    r_phase <= PH_IDLE;
                end
            endcase
        end
    end

    assign step_en    = (r_phase == PH_INIT) || (r_phase == PH_AD) ||
                        (r_phase == PH_ENC)  || (r_phase == PH_FIN);
    assign state_clr  = (r_phase == PH_IDLE) && start && !rst;
    assign busy       = (r_phase != PH_IDLE);
    assign done       = (r_phase == PH_DONE);
    assign phase_out  = r_phase;
    assign mbit_out   = w_mbit;
    assign ca_out     = w_ca;
    assign cb_out     = w_cb;
    assign cipher_out = r_cipher;
    assign tag_out    = r_tag;

endmodule

// File: tb/tb_acorn128_seq_ctrl.sv
// tb_acorn128_seq_ctrl
// Bench for the ACORN-128 phase sequencer. A small stand-in datapath produces
// ks_in from the DUT's own step stream. The reference model builds the whole
// job's expected message/control sequence from the phase rules. It then runs
// the same stand-in over that sequence to predict ciphertext and tag.
module tb_acorn128_seq_ctrl;

    localparam int AD_LEN   = 128;
    localparam int MSG_LEN  = 128;
    localparam int AD_BASE  = 1792;
    localparam int ENC_BASE = AD_BASE + AD_LEN + 256;
    localparam int FIN_BASE = ENC_BASE + MSG_LEN + 256;
    localparam int TOTAL    = FIN_BASE + 768;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [127:0]       key_in = '0;
    logic [127:0]       iv_in = '0;
    logic [AD_LEN-1:0]  ad_in = '0;
    logic [MSG_LEN-1:0] plaintext_in = '0;
    logic               ks_in;
    logic               state_clr, step_en, mbit_out, ca_out, cb_out;
    logic [2:0]         phase_out;
    logic               busy, done;
    logic [MSG_LEN-1:0] cipher_out;
    logic [127:0]       tag_out;

    int nCompared = 0;
    int nMismatched = 0;

    logic        ksForce = 1'b0;
    logic [31:0] dpState;

    // Expected per-step sequence and predicted results for the current job.
    logic expM[TOTAL];
    logic expCa[TOTAL];
    logic expCb[TOTAL];
    logic [MSG_LEN-1:0] expCipher;
    logic [127:0]       expTag;

    // Observed per-step trace and job-level observations.
    logic trM[TOTAL];
    logic trCa[TOTAL];
    logic trCb[TOTAL];
    int obsSteps, obsDone, obsClr, obsCtrlErr, obsSeqErr, obsAbortDone;
    logic obsClearedOk, obsIdleAfter, obsAbortData;
    logic [2:0] obsPrePhase;
    logic [9:0] obsAbortVec;

    logic [MSG_LEN-1:0] zeroCipher;
    logic [127:0]       zeroTag;

    acorn128_seq_ctrl #(.AD_LEN(AD_LEN), .MSG_LEN(MSG_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .iv_in(iv_in),
        .ad_in(ad_in), .plaintext_in(plaintext_in), .ks_in(ks_in),
        .state_clr(state_clr), .step_en(step_en), .mbit_out(mbit_out),
        .ca_out(ca_out), .cb_out(cb_out), .phase_out(phase_out), .busy(busy),
        .done(done), .cipher_out(cipher_out), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    // Stand-in datapath state update: a scrambled shift register, so every
    // message and control bit influences later keystream.
    function automatic logic [31:0] dpMix(input logic [31:0] s, input logic m,
                                          input logic ca, input logic cb);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0] ^ m;
        return {s[30:0], fb} ^ (ca ? 32'h9E3779B9 : 32'h0) ^ (cb ? 32'h7F4A7C15 : 32'h0);
    endfunction

    function automatic logic dpKs(input logic [31:0] s);
        return (^(s & 32'hA5C31E69)) ^ (s[17] & s[4]);
    endfunction

    // Stand-in datapath: cleared by state_clr and stepped on step_en.
    always @(posedge clk) begin
        if (state_clr) dpState <= 32'h0;
        else if (step_en) dpState <= dpMix(dpState, mbit_out, ca_out, cb_out);
    end

    assign ks_in = ksForce ? 1'b1 : dpKs(dpState);

    function automatic logic [2:0] expPhaseOf(input int idx);
        if (idx < AD_BASE) return 3'd1;
        if (idx < ENC_BASE) return 3'd2;
        if (idx < FIN_BASE) return 3'd3;
        return 3'd4;
    endfunction

    // Reference model: per-phase message/padding rules written as plain loops,
    // then the stand-in datapath run over the resulting sequence.
    task automatic buildModel(input logic [127:0] k, input logic [127:0] v,
                              input logic [AD_LEN-1:0] a, input logic [MSG_LEN-1:0] p,
                              input logic force1);
        logic [31:0] s;
        logic kb;
        int n;
        n = 0;
        for (int i = 0; i < 1792; i++) begin
            if (i < 128) expM[n] = k[i];
            else if (i < 256) expM[n] = v[i - 128];
            else if (i == 256) expM[n] = ~k[0];
            else expM[n] = k[i % 128];
            expCa[n] = 1'b1; expCb[n] = 1'b1; n++;
        end
        for (int i = 0; i < AD_LEN + 256; i++) begin
            expM[n]  = (i < AD_LEN) ? a[i] : (i == AD_LEN);
            expCa[n] = (i < AD_LEN + 128);
            expCb[n] = 1'b1; n++;
        end
        for (int i = 0; i < MSG_LEN + 256; i++) begin
            expM[n]  = (i < MSG_LEN) ? p[i] : (i == MSG_LEN);
            expCa[n] = (i < MSG_LEN + 128);
            expCb[n] = 1'b0; n++;
        end
        for (int i = 0; i < 768; i++) begin
            expM[n] = 1'b0; expCa[n] = 1'b1; expCb[n] = 1'b1; n++;
        end
        s = 32'h0;
        expCipher = '0;
        expTag = '0;
        for (int i = 0; i < TOTAL; i++) begin
            kb = force1 ? 1'b1 : dpKs(s);
            if (i >= ENC_BASE && i < ENC_BASE + MSG_LEN) expCipher[i - ENC_BASE] = p[i - ENC_BASE] ^ kb;
            if (i >= FIN_BASE + 640) expTag[i - FIN_BASE - 640] = kb;
            s = dpMix(s, expM[i], expCa[i], expCb[i]);
        end
    endtask

    // Drive one job and record what the DUT does, cycle by cycle. Cycle 0 is
    // the start cycle. rePulseAt/abortAt (-1 = unused) inject a second start
    // or a reset in that cycle.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] v,
                                 input logic [AD_LEN-1:0] a, input logic [MSG_LEN-1:0] p,
                                 input int rePulseAt, input int abortAt);
        bit finished;
        obsSteps = 0; obsDone = -1; obsClr = 0; obsCtrlErr = 0; obsSeqErr = 0;
        obsClearedOk = 1'b0; obsIdleAfter = 1'b0; obsAbortVec = '1; obsAbortData = 1'b1;
        obsAbortDone = 0; obsPrePhase = 3'd0;
        finished = 1'b0;
        @(negedge clk);
        key_in = k; iv_in = v; ad_in = a; plaintext_in = p; start = 1'b1;
        #1;
        if (state_clr) obsClr++;
        for (int cyc = 1; cyc <= TOTAL + 16 && !finished; cyc++) begin
            @(negedge clk);
            start = (cyc == rePulseAt);
            if (cyc == rePulseAt) key_in = ~k;
            if (cyc == abortAt) begin
                obsPrePhase = phase_out;
                rst = 1'b1;
                @(posedge clk);
                #1;
                obsAbortVec = {state_clr, step_en, mbit_out, ca_out, cb_out, phase_out, busy, done};
                obsAbortData = (cipher_out != '0) || (tag_out != '0);
                @(negedge clk);
                rst = 1'b0;
                for (int w = 0; w < 4; w++) begin
                    @(negedge clk); #1;
                    if (done || busy) obsAbortDone++;
                end
                finished = 1'b1;
            end else begin
                #1;
                if (state_clr) obsClr++;
                if (cyc == 1) obsClearedOk = (cipher_out == '0) && (tag_out == '0);
                if (step_en) begin
                    if (obsSteps < TOTAL) begin
                        trM[obsSteps] = mbit_out; trCa[obsSteps] = ca_out; trCb[obsSteps] = cb_out;
                        if ({mbit_out, ca_out, cb_out} !== {expM[obsSteps], expCa[obsSteps], expCb[obsSteps]})
                            obsCtrlErr++;
                        if (phase_out !== expPhaseOf(obsSteps)) obsSeqErr++;
                    end
                    if (!busy || done) obsSeqErr++;
                    obsSteps++;
                end else if (done) begin
                    obsDone = cyc;
                    if (phase_out !== 3'd5 || !busy) obsSeqErr++;
                    finished = 1'b1;
                end else begin
                    obsSeqErr++;
                end
            end
        end
        start = 1'b0;
        if (obsDone >= 0) begin
            @(negedge clk); #1;
            obsIdleAfter = !done && !busy && (phase_out == 3'd0) && !step_en;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nCompared++;
        if ({state_clr, step_en, mbit_out, ca_out, cb_out, phase_out, busy, done} !== 10'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl: got %b want 0", {state_clr, step_en, mbit_out, ca_out, cb_out, phase_out, busy, done});
        end
        nCompared++;
        if (cipher_out !== '0) begin nMismatched++; $display("[TB] FAIL reset_cipher: got %h want 0", cipher_out); end
        nCompared++;
        if (tag_out !== '0) begin nMismatched++; $display("[TB] FAIL reset_tag: got %h want 0", tag_out); end
        rst = 1'b0;
    endtask

    task automatic test_zero_vector();
        buildModel('0, '0, '0, '0, 1'b0);
        applyStimulus('0, '0, '0, '0, -1, -1);
        nCompared++;
        if (obsSteps !== TOTAL) begin nMismatched++; $display("[TB] FAIL zero_steps: got %0d want %0d", obsSteps, TOTAL); end
        nCompared++;
        if (obsDone !== TOTAL + 1) begin nMismatched++; $display("[TB] FAIL zero_done_cycle: got %0d want %0d", obsDone, TOTAL + 1); end
        nCompared++;
        if (obsClr !== 1) begin nMismatched++; $display("[TB] FAIL zero_state_clr: got %0d pulses want 1", obsClr); end
        nCompared++;
        if (obsCtrlErr !== 0) begin nMismatched++; $display("[TB] FAIL zero_ctrl_trace: got %0d bad steps want 0", obsCtrlErr); end
        nCompared++;
        if (obsSeqErr !== 0) begin nMismatched++; $display("[TB] FAIL zero_sequence: got %0d bad cycles want 0", obsSeqErr); end
        nCompared++;
        if (cipher_out !== expCipher) begin nMismatched++; $display("[TB] FAIL zero_cipher: got %h want %h", cipher_out, expCipher); end
        nCompared++;
        if (tag_out !== expTag) begin nMismatched++; $display("[TB] FAIL zero_tag: got %h want %h", tag_out, expTag); end
        nCompared++;
        if (obsIdleAfter !== 1'b1) begin nMismatched++; $display("[TB] FAIL zero_idle_after_done: got %b want 1", obsIdleAfter); end
        zeroCipher = expCipher;
        zeroTag = expTag;
    endtask

    task automatic test_init_trace();
        logic [127:0] k;
        logic [127:0] v;
        int   idx[7];
        logic want[7];
        logic [MSG_LEN-1:0] p;
        k = 128'h0F0E0D0C0B0A09080706050403020100;
        v = 128'h0102030405060708090A0B0C0D0E0F10;
        p = {$urandom, $urandom, $urandom, $urandom};
        idx  = '{0, 127, 128, 255, 256, 257, 1791};
        want = '{k[0], k[127], v[0], v[127], ~k[0], k[1], k[127]};
        buildModel(k, v, '0, p, 1'b0);
        applyStimulus(k, v, '0, p, -1, -1);
        for (int n = 0; n < 7; n++) begin
            nCompared++;
            if (trM[idx[n]] !== want[n]) begin
                nMismatched++;
                $display("[TB] FAIL init_mbit_step%0d: got %b want %b", idx[n], trM[idx[n]], want[n]);
            end
        end
        nCompared++;
        if (cipher_out !== expCipher) begin nMismatched++; $display("[TB] FAIL init_cipher: got %h want %h", cipher_out, expCipher); end
    endtask

    task automatic test_padding_trace();
        int pts[7];
        logic [1:0] wantCc[7];
        int onesAd, onesEnc;
        pts    = '{AD_BASE + 127, AD_BASE + 128, AD_BASE + 255, AD_BASE + 256, AD_BASE + 383,
                   ENC_BASE + 255, ENC_BASE + 256};
        wantCc = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00};
        buildModel({$urandom, $urandom, $urandom, $urandom}, '1, '0, '0, 1'b0);
        applyStimulus({expM[127], 127'h0}, '1, '0, '0, -1, -1);
        for (int n = 0; n < 7; n++) begin
            nCompared++;
            if ({trCa[pts[n]], trCb[pts[n]]} !== wantCc[n]) begin
                nMismatched++;
                $display("[TB] FAIL pad_cacb_step%0d: got %b want %b", pts[n], {trCa[pts[n]], trCb[pts[n]]}, wantCc[n]);
            end
        end
        onesAd = 0; onesEnc = 0;
        for (int i = 128; i < 384; i++) begin
            if (trM[AD_BASE + i] === 1'b1) onesAd++;
            if (trM[ENC_BASE + i] === 1'b1) onesEnc++;
        end
        nCompared++;
        if (onesAd !== 1 || trM[AD_BASE + 128] !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL pad_ad_mbit: got %0d ones (step128=%b) want 1 at step128", onesAd, trM[AD_BASE + 128]);
        end
        nCompared++;
        if (onesEnc !== 1 || trM[ENC_BASE + 128] !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL pad_enc_mbit: got %0d ones (step128=%b) want 1 at step128", onesEnc, trM[ENC_BASE + 128]);
        end
    endtask

    task automatic test_ks_forced();
        logic [MSG_LEN-1:0] p;
        p = {16{8'hA5}};
        ksForce = 1'b1;
        buildModel('0, '0, '0, p, 1'b1);
        applyStimulus('0, '0, '0, p, -1, -1);
        nCompared++;
        if (cipher_out !== {16{8'h5A}}) begin nMismatched++; $display("[TB] FAIL forced_cipher: got %h want %h", cipher_out, {16{8'h5A}}); end
        nCompared++;
        if (tag_out !== {128{1'b1}}) begin nMismatched++; $display("[TB] FAIL forced_tag: got %h want all ones", tag_out); end
        ksForce = 1'b0;
    endtask

    task automatic test_restart_ignored();
        buildModel('0, '0, '0, '0, 1'b0);
        applyStimulus('0, '0, '0, '0, 1000, -1);
        nCompared++;
        if (obsDone !== TOTAL + 1 || obsSteps !== TOTAL) begin
            nMismatched++; $display("[TB] FAIL restart_timing: got done %0d steps %0d want %0d/%0d", obsDone, obsSteps, TOTAL + 1, TOTAL);
        end
        nCompared++;
        if (obsClr !== 1) begin nMismatched++; $display("[TB] FAIL restart_state_clr: got %0d pulses want 1", obsClr); end
        nCompared++;
        if (cipher_out !== zeroCipher || tag_out !== zeroTag) begin
            nMismatched++; $display("[TB] FAIL restart_result: got %h/%h want %h/%h", cipher_out, tag_out, zeroCipher, zeroTag);
        end
    endtask

    task automatic test_abort();
        logic [127:0] k, v;
        logic [MSG_LEN-1:0] p;
        logic [AD_LEN-1:0] a;
        k = {$urandom, $urandom, $urandom, $urandom};
        v = {$urandom, $urandom, $urandom, $urandom};
        a = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        buildModel(k, v, a, p, 1'b0);
        applyStimulus(k, v, a, p, -1, 2500);
        nCompared++;
        if (obsPrePhase !== 3'd3) begin nMismatched++; $display("[TB] FAIL abort_pre_phase: got %0d want 3", obsPrePhase); end
        nCompared++;
        if (obsAbortVec !== 10'b0) begin nMismatched++; $display("[TB] FAIL abort_outputs: got %b want 0", obsAbortVec); end
        nCompared++;
        if (obsAbortData !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_data: got %b want 0 (cipher/tag cleared)", obsAbortData); end
        nCompared++;
        if (obsAbortDone !== 0) begin nMismatched++; $display("[TB] FAIL abort_no_done: got %0d busy/done cycles want 0", obsAbortDone); end
        k = {$urandom, $urandom, $urandom, $urandom};
        buildModel(k, v, a, p, 1'b0);
        applyStimulus(k, v, a, p, -1, -1);
        nCompared++;
        if (obsDone !== TOTAL + 1) begin nMismatched++; $display("[TB] FAIL abort_fresh_done: got %0d want %0d", obsDone, TOTAL + 1); end
        nCompared++;
        if (cipher_out !== expCipher || tag_out !== expTag) begin
            nMismatched++; $display("[TB] FAIL abort_fresh_result: got %h/%h want %h/%h", cipher_out, tag_out, expCipher, expTag);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k, v;
        logic [MSG_LEN-1:0] p;
        logic [AD_LEN-1:0] a;
        for (int j = 0; j < 3; j++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            v = {$urandom, $urandom, $urandom, $urandom};
            a = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            buildModel(k, v, a, p, 1'b0);
            applyStimulus(k, v, a, p, -1, -1);
            nCompared++;
            if (obsClearedOk !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_clear_job%0d: got %b want 1", j, obsClearedOk); end
            nCompared++;
            if (obsCtrlErr !== 0 || obsSeqErr !== 0) begin
                nMismatched++; $display("[TB] FAIL b2b_trace_job%0d: got %0d/%0d bad steps want 0/0", j, obsCtrlErr, obsSeqErr);
            end
            nCompared++;
            if (cipher_out !== expCipher) begin nMismatched++; $display("[TB] FAIL b2b_cipher_job%0d: got %h want %h", j, cipher_out, expCipher); end
            nCompared++;
            if (tag_out !== expTag) begin nMismatched++; $display("[TB] FAIL b2b_tag_job%0d: got %h want %h", j, tag_out, expTag); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_init_trace();
        test_padding_trace();
        test_ks_forced();
        test_restart_ignored();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/acorn128_seq_ctrl.md
Name: acorn128_seq_ctrl

Overview:
Phase sequencer for the ACORN-128 bit-serial state-update datapath (state_update128 + ksg128).
- Accepts a one-shot job (key, IV, one AD block, one plaintext block).
- Drives the datapath through INIT, AD, ENC and FIN, one state step per cycle, generating the per-step message bit and the ca/cb control bits.
- Captures keystream into ciphertext and tag registers and reports completion with a busy/done handshake.
- Sits between the host/AXI wrapper and the datapath; it replaces ad-hoc per-phase counters in each phase module.

Parameters:
AD_LEN, 128, associated-data length in bits (1..1024).
MSG_LEN, 128, plaintext length in bits (1..1024).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  job request; sampled only in IDLE.
key_in  in  128  key; bit 0 is used first.
iv_in  in  128  IV; bit 0 is used first.
ad_in  in  AD_LEN  associated data; bit 0 is used first.
plaintext_in  in  MSG_LEN  plaintext; bit 0 is used first.
ks_in  in  1  keystream bit from ksg128 for the current (pre-update) state.
state_clr  out  1  one-cycle pulse; datapath zeroes its 293-bit state.
step_en  out  1  datapath performs one state update at this clock edge.
mbit_out  out  1  message bit for the current step.
ca_out  out  1  ca control bit for the current step.
cb_out  out  1  cb control bit for the current step.
phase_out  out  3  0 IDLE, 1 INIT, 2 AD, 3 ENC, 4 FIN, 5 DONE.
busy  out  1  high whenever phase is not IDLE.
done  out  1  one-cycle pulse when the job is complete.
cipher_out  out  MSG_LEN  ciphertext.
tag_out  out  128  authentication tag.

Behaviour:
- Reset (synchronous, rst high at posedge): phase=IDLE, step counter=0, all outputs 0, cipher_out=0, tag_out=0, latched inputs cleared. Reset in any phase aborts the job immediately, with no done pulse.
- Step counter: 11 bits, cleared on every phase entry, increments on each step_en cycle.
- IDLE: step_en=0.
  - On start=1, latch key/iv/ad/plaintext, pulse state_clr in that same cycle, and go to INIT (step 0) next cycle.
  - start while busy is ignored and does not alter latched data.
- INIT, 1792 steps, ca=1, cb=1:
  - mbit = key[i] for i<128.
  - mbit = iv[i-128] for 128≤i<256.
  - mbit = key[0]^1 for i=256.
  - mbit = key[i mod 128] for 257≤i<1792.
- AD, AD_LEN+256 steps, cb=1:
  - i<AD_LEN: mbit=ad[i], ca=1.
  - i=AD_LEN: mbit=1, ca=1.
  - AD_LEN<i<AD_LEN+128: mbit=0, ca=1.
  - Remaining 128 steps: mbit=0, ca=0.
- ENC, MSG_LEN+256 steps, cb=0:
  - i<MSG_LEN: mbit=plaintext[i], ca=1, and at that edge cipher_out[i] <= plaintext[i]^ks_in.
  - Padding (1, then zeros) and ca pattern are identical to AD.
- FIN, 768 steps, ca=1, cb=1, mbit=0.
  - At steps 640..767, tag_out[i-640] <= ks_in.
- DONE: one cycle, done=1, step_en=0, then IDLE.
- Output hold: cipher_out and tag_out hold until the next accepted start, which clears them to 0.
- step_en: 1 in every INIT/AD/ENC/FIN cycle. mbit/ca/cb are combinational from phase and counter, valid while step_en=1, and 0 otherwise.
- Phase transitions: occur at the edge of the last step of each phase; no bubble cycles between phases.
- Latency (defaults): start accepted in cycle 0; steps in cycles 1..3328 (1792+384+384+768); done in cycle 3329; busy high in cycles 1..3329.
- ks_in sampling: only at the ENC and FIN capture steps listed above; ignored elsewhere.

Test Plan:
1. Reset, then key=0, iv=0, ad=0, pt=0, start pulse. Required: exactly 3328 step_en cycles, done at cycle 3329, one state_clr pulse in cycle 0, and cipher_out/tag_out equal the C reference model outputs for the all-zero vector.
2. key=128'h0F0E…00, iv=128'h01…10. Required: trace mbit at INIT steps 0, 127, 128, 255, 256, 257, 1791 equals key[0], key[127], iv[0], iv[127], key[0]^1, key[1], key[127].
3. ca/cb trace at AD steps 127/128/255/256/383 and ENC steps 255/256 equals 1/1, 1/1, 1/1, 0/1, 0/1 and 1/0, 0/0; mbit=1 only at AD step 128 and ENC step 128 within padding.
4. Force ks_in=1 constant with pt=128'hA5A5…: cipher_out=128'h5A5A…, tag_out=all-ones.
5. start re-pulsed at cycle 1000 with different key: ignored, and final result is unchanged versus scenario 1.
6. rst asserted at cycle 2500 (ENC phase): next cycle phase=IDLE, all outputs 0, no done; a following fresh job completes correctly.
